// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable flags and error counters.
// Define FIFO_FWFT_EN for first-word-fall-through read data; default is registered read data.
module fifo_sync_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write,
  input  logic [DATA_W-1:0]          data_write,
  input  logic                       read,
  output logic [DATA_W-1:0]          data_read,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err_write,
  output logic                       err_read,
  output logic [7:0]                 err_cnt,
  input  logic                       clr_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic [CW-1:0]     count_q;
  logic              err_write_q;
  logic              err_read_q;
  logic [7:0]        err_cnt_q;

  logic              wr_ok;
  logic              rd_ok;
  logic              err_write_next;
  logic              err_read_next;
  logic [8:0]        err_sum;
  logic [7:0]        err_cnt_next;

  assign full         = (count_q == FULL_LVL);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_LVL);
  assign almost_empty = (count_q <= AE_LVL);
  assign count        = count_q;
  assign err_write    = err_write_q;
  assign err_read     = err_read_q;
  assign err_cnt      = err_cnt_q;

  // A read frees a slot on the same edge, so a full FIFO still accepts a paired write.
  assign wr_ok          = write & (~full | read);
  assign rd_ok          = read & ~empty;
  assign err_write_next = write & ~wr_ok;
  assign err_read_next  = read & ~rd_ok;

  // Nine-bit sum catches the carry out of 255 for saturation.
  assign err_sum      = {1'b0, err_cnt_q} + 9'(err_write_next) + 9'(err_read_next);
  assign err_cnt_next = err_sum[8] ? 8'hFF : err_sum[7:0];

  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      mem[wp] <= data_write;
    end
  end

`ifdef FIFO_FWFT_EN
  assign data_read = empty ? '0 : mem[rp];
`else
  logic [DATA_W-1:0] data_read_q;

  assign data_read = data_read_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_read_q <= '0;
    end else if (rd_ok) begin
      data_read_q <= mem[rp];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wp          <= '0;
      rp          <= '0;
      count_q     <= '0;
      err_write_q <= 1'b0;
      err_read_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      if (wr_ok) begin
        wp <= wp + AW'(1);
      end
      if (rd_ok) begin
        rp <= rp + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      err_write_q <= err_write_next;
      err_read_q  <= err_read_next;
      if (clr_err) begin
        err_cnt_q <= '0;
      end else begin
        err_cnt_q <= err_cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: directed steps plus seeded random traffic
// compared against a queue-based reference model.
module tb_fifo_sync_param;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 16;

  logic              clk;
  logic              reset;
  logic              write;
  logic [DATA_W-1:0] data_write;
  logic              read;
  logic [DATA_W-1:0] data_read;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [4:0]        count;
  logic              err_write;
  logic              err_read;
  logic [7:0]        err_cnt;
  logic              clr_err;

  fifo_sync_param #(
    .DATA_W   (32),
    .DEPTH    (16),
    .AF_LEVEL (14),
    .AE_LEVEL (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .write        (write),
    .data_write   (data_write),
    .read         (read),
    .data_read    (data_read),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .err_write    (err_write),
    .err_read     (err_read),
    .err_cnt      (err_cnt),
    .clr_err      (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] q[$];
  logic [31:0] m_dr;
  logic        m_ew;
  logic        m_er;
  int          m_ec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data();
`ifdef FIFO_FWFT_EN
    return (q.size() != 0) ? q[0] : 32'h0;
`else
    return m_dr;
`endif
  endfunction

  task automatic model_edge(input logic rst, input logic w, input logic [31:0] d,
                            input logic r, input logic c);
    bit is_full, is_empty, w_ok, r_ok;
    logic [31:0] popped;
    if (rst) begin
      q.delete();
      m_dr = '0;
      m_ew = 1'b0;
      m_er = 1'b0;
      m_ec = 0;
    end else begin
      is_full  = (q.size() == DEPTH);
      is_empty = (q.size() == 0);
      w_ok = w && (!is_full || r);
      r_ok = r && !is_empty;
      if (r_ok) begin
        popped = q.pop_front();
        m_dr   = popped;
      end
      if (w_ok) q.push_back(d);
      m_ew = w && !w_ok;
      m_er = r && !r_ok;
      if (c) m_ec = 0;
      else begin
        m_ec = m_ec + int'(m_ew) + int'(m_er);
        if (m_ec > 255) m_ec = 255;
      end
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count",        32'(count),        32'(n));
    chk("empty",        32'(empty),        32'(n == 0));
    chk("full",         32'(full),         32'(n == 16));
    chk("almost_full",  32'(almost_full),  32'(n >= 14));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
    chk("data_read",    data_read,         exp_data());
    chk("err_write",    32'(err_write),    32'(m_ew));
    chk("err_read",     32'(err_read),     32'(m_er));
    chk("err_cnt",      32'(err_cnt),      32'(m_ec));
  endtask

  task automatic step(input logic rst, input logic w, input logic [31:0] d,
                      input logic r, input logic c);
    reset      = rst;
    write      = w;
    data_write = d;
    read       = r;
    clr_err    = c;
    @(posedge clk);
    #1;
    model_edge(rst, w, d, r, c);
    check_all();
  endtask

  initial begin
    logic w, r;
    logic [31:0] d;
    reset = 1'b1; write = 1'b0; read = 1'b0; clr_err = 1'b0; data_write = '0;
    q.delete(); m_dr = '0; m_ew = 1'b0; m_er = 1'b0; m_ec = 0;

    // Reset then idle
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ae",    32'(almost_empty), 32'd1);
    chk("rst_full",  32'(full), 32'd0);
    chk("rst_af",    32'(almost_full), 32'd0);
    chk("rst_dr",    data_read, 32'd0);
    chk("rst_ecnt",  32'(err_cnt), 32'd0);

    // Fill and drain 16 words
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 32'hA000_0000 + 32'(i), 0, 0);
      if (i == 13) chk("af_at_14", 32'(almost_full), 32'd1);
      if (i == 14) chk("notfull_15", 32'(full), 32'd0);
    end
    chk("full_at_16", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 1, 0);
`ifndef FIFO_FWFT_EN
      chk("drain_data", data_read, 32'hA000_0000 + 32'(i));
`endif
    end
    chk("drained_empty", 32'(empty), 32'd1);

    // Overflow attempt
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 32'hA000_0000 + 32'(i), 0, 0);
    step(0, 1, 32'h5555_5555, 0, 0);
    chk("ovf_errw",  32'(err_write), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_ecnt",  32'(err_cnt), 32'd1);
`ifdef FIFO_FWFT_EN
    chk("ovf_head", data_read, 32'hA000_0000);
`endif
    step(0, 0, 0, 1, 0);
    chk("ovf_errw_drop", 32'(err_write), 32'd0);
`ifndef FIFO_FWFT_EN
    chk("ovf_first", data_read, 32'hA000_0000);
`endif

    // Simultaneous write+read while full
    step(0, 1, 32'hA000_0010, 0, 0);
    step(0, 1, 32'hDEAD_BEEF, 1, 0);
    chk("full_wr_rd_count", 32'(count), 32'd16);
    chk("full_wr_rd_errw",  32'(err_write), 32'd0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0);
`ifndef FIFO_FWFT_EN
    chk("beef_last", data_read, 32'hDEAD_BEEF);
`endif
    chk("beef_empty", 32'(empty), 32'd1);

    // Simultaneous write+read while empty
    step(1, 0, 0, 0, 0);
    step(0, 1, 32'h1234_5678, 1, 0);
    chk("emp_errr",  32'(err_read), 32'd1);
    chk("emp_count", 32'(count), 32'd1);
    chk("emp_ecnt",  32'(err_cnt), 32'd1);
    step(0, 0, 0, 1, 0);
`ifndef FIFO_FWFT_EN
    chk("emp_data", data_read, 32'h1234_5678);
`endif
    chk("emp_errr_drop", 32'(err_read), 32'd0);

    // Random interleaved traffic, seed 2
    step(1, 0, 0, 0, 0);
    void'($urandom(2));
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      d = $urandom();
      step(0, w, d, r, 0);
    end
    // Long write-biased run to force pointer wrap
    for (int i = 0; i < 60; i++) begin
      w = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 1) != 0);
      d = $urandom();
      step(0, w, d, r, 0);
    end

    // Mid-burst reset with five words stored
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 32'hC000_0000 + 32'(i), 0, 0);
    chk("pre_rst_count", 32'(count), 32'd5);
    step(1, 1, 32'h7777_7777, 0, 0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    step(0, 0, 0, 1, 0);
    chk("post_rst_read_rej", 32'(err_read), 32'd1);

    // Error counter saturation and clear priority
    for (int i = 0; i < 300; i++) step(0, 0, 0, 1, 0);
    chk("ecnt_sat", 32'(err_cnt), 32'd255);
    step(0, 1, 32'h0, 1, 0);
    step(0, 1, 32'h1, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 32'(i), 0, 0);
    chk("ecnt_hold", 32'(err_cnt), 32'd255);
    step(0, 1, 32'h2, 0, 1);
    chk("ecnt_clr", 32'(err_cnt), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("ecnt_after_clr", 32'(err_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised synchronous single-clock FIFO; the next generation of the team's top_fifo.
- Adds configurable width and depth, an exact occupancy count, programmable almost-full/almost-empty flags, per-cycle error pulses and saturating error counters.
- Sits between producer and consumer blocks in one clock domain.

Parameters:
- DATA_W, 32, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=4.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).
- Derived: AW = $clog2(DEPTH); CW = AW+1.

Ports:
- clk, input, 1, rising-edge clock for all state.
- reset, input, 1, synchronous active-high reset; sampled on rising edge of clk.
- write, input, 1, write request.
- data_write, input, DATA_W, write data; sampled when a write is accepted.
- read, input, 1, read request.
- data_read, output, DATA_W, read data.
- full, output, 1, count == DEPTH.
- empty, output, 1, count == 0.
- almost_full, output, 1, count >= AF_LEVEL.
- almost_empty, output, 1, count <= AE_LEVEL.
- count, output, CW, number of stored words (0..DEPTH).
- err_write, output, 1, one-cycle pulse: write rejected (overflow attempt).
- err_read, output, 1, one-cycle pulse: read rejected (underflow attempt).
- err_cnt, output, 8, saturating count of rejected requests (read + write).
- clr_err, input, 1, synchronous clear of err_cnt.

Behaviour:
- Storage: DEPTH x DATA_W register array. Write pointer wp and read pointer rp are AW bits and wrap naturally from DEPTH-1 to 0. A separate CW-bit count register holds occupancy.
- Accept rules, evaluated on the same edge:
  - wr_ok = write & (~full | read)
  - rd_ok = read & ~empty
- Full with write and read together: both are accepted, count is unchanged, and data_read returns the oldest word.
- Empty with write and read together: the write is accepted, the read is rejected, err_read pulses, and count becomes 1.
- Rejected requests:
  - err_write = write & ~wr_ok, registered, so it is high for exactly the cycle after the rejected request.
  - err_read = read & ~rd_ok, registered the same way.
  - A rejected request leaves pointers, count and memory unchanged.
- Count update: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither are accepted.
- Flags: full, empty, almost_full and almost_empty decode combinationally from the count register. They are valid in the cycle after the edge that changed count and have no additional latency.
- Read latency (default mode): on an rd_ok edge, data_read loads mem[rp], so data is visible in the next cycle. data_read holds its last value when no read is accepted.
- err_cnt:
  - Increments by (err_write_next + err_read_next), i.e. by 0, 1 or 2, and saturates at 255.
  - clr_err has priority over an increment in the same cycle; the counter becomes 0.
- Reset (priority over all other inputs):
  - wp = rp = 0, count = 0, data_read = 0.
  - err_write = err_read = 0, err_cnt = 0.
  - Resulting flags: empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - Memory contents are not cleared.
  - A reset in the middle of a burst discards all stored data. The first read after reset that is not preceded by a write is rejected.
- Pointer wrap: after DEPTH accepted writes and DEPTH accepted reads in any interleaving, wp = rp again and data order is preserved across the wrap.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined (first-word-fall-through mode):
  - data_read = mem[rp] combinationally whenever empty = 0, and shows 0 when empty.
  - An accepted read advances rp, and data_read shows the next word in the same cycle after the edge.
  - Accept rules, flags and counters are identical to the default mode.
- Undefined: registered read data with 1-cycle latency, as described under Behaviour.

Test Plan (all scenarios use DATA_W = 32, DEPTH = 16, AF_LEVEL = 14, AE_LEVEL = 2):
- Reset then idle -> count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, data_read = 0, err_cnt = 0.
- Write 16 words 0xA000_0000 + i, then read 16 words:
  - count steps 0..16 and back to 0.
  - almost_full rises when count reaches 14; full rises at 16.
  - data_read returns 0xA000_0000 .. 0xA000_000F in order, 1 cycle after each read (0 cycles with FIFO_FWFT_EN).
- Fill to 16, then one write only -> err_write pulses for 1 cycle, count stays 16, err_cnt = 1; the next read returns 0xA000_0000.
- Full with write (0xDEAD_BEEF) and read in the same cycle -> both accepted, count stays 16, 0xDEAD_BEEF is read out last.
- Empty with write (0x1234_5678) and read in the same cycle -> err_read pulses, count = 1, err_cnt = 1; a following read returns 0x1234_5678.
- Wrap-around, reset and counter checks:
  - 40 random interleaved write/read cycles with seed 2 -> read stream matches a reference queue.
  - Reset asserted with count = 5 -> count = 0 and empty = 1 on the next cycle.
  - 300 reads while empty -> err_cnt saturates at 255; clr_err then sets err_cnt = 0.
